sample_stream_conditioner: RTL and testbench

- Sits directly downstream of the packet-to-sample unpacker in the real-time data feed.
- Absorbs gaps in the unpacker's 3-bit sample stream, which stalls whenever the packet FIFO runs dry, using a small elastic buffer.
- Releases samples to the correlator front end as a gap-free, one-per-cycle stream once a prefill threshold is met.
- Counts underruns and overflows for debug.

---
 rtl/sample_stream_conditioner.sv | 113 +++++++++++
 tb/tb_sample_stream_conditioner.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sample_stream_conditioner.sv
// Elastic buffer between the packet-to-sample unpacker and the correlator
// front end. Soaks up unpacker stalls, then plays samples out one per cycle
// once PREFILL samples are banked. Underruns and dropped samples are counted
// (saturating) for debug.
module sample_stream_conditioner #(
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int PREFILL = 8,
  parameter int CNT_W   = 16
) (
  input  logic              clk_sample,
  input  logic              reset,
  input  logic              enable,
  input  logic              in_valid,
  input  logic [2:0]        in_data,
  output logic              out_valid,
  output logic [2:0]        out_data,
  output logic [1:0]        state,
  output logic [ADDR_W:0]   fill_level,
  output logic [CNT_W-1:0]  underrun_count,
  output logic [CNT_W-1:0]  overflow_count
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PREFILL = 2'd1,
    S_RUN     = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] L_DEPTH   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] L_PREFILL = (ADDR_W+1)'(PREFILL);

  state_t             r_state;
  logic [2:0]         r_mem [DEPTH];
  logic [ADDR_W-1:0]  r_wr_ptr;
  logic [ADDR_W-1:0]  r_rd_ptr;
  logic [ADDR_W:0]    r_fill;
  logic               r_out_valid;
  logic [2:0]         r_out_data;
  logic [CNT_W-1:0]   r_und_cnt;
  logic [CNT_W-1:0]   r_ovf_cnt;

  logic w_active;
  logic w_rd;
  logic w_wr;
  logic w_drop;

  // Strobes come from registered state only. Enable low suppresses all
  // buffer activity so a flush never moves data or bumps a counter.
  assign w_active = enable && (r_state != S_IDLE);
  assign w_rd     = enable && (r_state == S_RUN) && (r_fill != '0);
  // A full buffer still accepts a sample when a read frees a slot this cycle.
  assign w_wr     = in_valid && w_active && ((r_fill < L_DEPTH) || w_rd);
  assign w_drop   = in_valid && w_active && !w_wr;

  // Sample storage; contents need no reset since fill_level guards reads.
  always_ff @(posedge clk_sample) begin
    if (!reset && w_wr) r_mem[r_wr_ptr] <= in_data;
  end

  // Control: state machine, pointers, fill count, output register, counters.
  always_ff @(posedge clk_sample) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_fill      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= 3'd0;
      r_und_cnt   <= '0;
      r_ovf_cnt   <= '0;
    end else if (!enable) begin
      // Flush; debug counters deliberately survive a disable.
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_fill      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= 3'd0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_fill <= r_fill + 1'b1;
        2'b01:   r_fill <= r_fill - 1'b1;
        default: r_fill <= r_fill;
      endcase
      r_out_valid <= w_rd;
      r_out_data  <= w_rd ? r_mem[r_rd_ptr] : 3'd0;
      if (w_drop && (r_ovf_cnt != '1)) r_ovf_cnt <= r_ovf_cnt + 1'b1;
      case (r_state)
        S_IDLE:    r_state <= S_PREFILL;
        // The cycle that crosses the threshold does not read; RUN reads next.
        S_PREFILL: if (r_fill >= L_PREFILL) r_state <= S_RUN;
        S_RUN: begin
          if (r_fill == '0) begin
            r_state <= S_PREFILL;
            if (r_und_cnt != '1) r_und_cnt <= r_und_cnt + 1'b1;
          end
        end
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  assign out_valid      = r_out_valid;
  assign out_data       = r_out_data;
  assign state          = r_state;
  assign fill_level     = r_fill;
  assign underrun_count = r_und_cnt;
  assign overflow_count = r_ovf_cnt;

endmodule

// File: tb/tb_sample_stream_conditioner.sv
// Bench for sample_stream_conditioner. Three instances share one stimulus
// stream: defaults, PREFILL=DEPTH=16 (overflow corner), and CNT_W=2
// (counter saturation). Each is compared every cycle to a queue-based model.
module tb_sample_stream_conditioner;

  logic       clk = 1'b0;
  logic       rst, en, iv;
  logic [2:0] id;

  always #5 clk = ~clk;

  logic       ov [3];
  logic [2:0] od [3];
  logic [1:0] st [3];
  logic [4:0] fl [3];
  logic [15:0] uc0, oc0, uc1, oc1;
  logic [1:0]  uc2, oc2;

  sample_stream_conditioner #(.DEPTH(16), .ADDR_W(4), .PREFILL(8), .CNT_W(16)) u_d0 (
    .clk_sample(clk), .reset(rst), .enable(en), .in_valid(iv), .in_data(id),
    .out_valid(ov[0]), .out_data(od[0]), .state(st[0]), .fill_level(fl[0]),
    .underrun_count(uc0), .overflow_count(oc0));

  sample_stream_conditioner #(.DEPTH(16), .ADDR_W(4), .PREFILL(16), .CNT_W(16)) u_d1 (
    .clk_sample(clk), .reset(rst), .enable(en), .in_valid(iv), .in_data(id),
    .out_valid(ov[1]), .out_data(od[1]), .state(st[1]), .fill_level(fl[1]),
    .underrun_count(uc1), .overflow_count(oc1));

  sample_stream_conditioner #(.DEPTH(16), .ADDR_W(4), .PREFILL(8), .CNT_W(2)) u_d2 (
    .clk_sample(clk), .reset(rst), .enable(en), .in_valid(iv), .in_data(id),
    .out_valid(ov[2]), .out_data(od[2]), .state(st[2]), .fill_level(fl[2]),
    .underrun_count(uc2), .overflow_count(oc2));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference model: the buffer is a plain FIFO queue; mode 0/1/2 = idle/prefill/run.
  int         p_depth [3] = '{16, 16, 16};
  int         p_pre   [3] = '{8, 16, 8};
  int         p_cmax  [3] = '{65535, 65535, 3};
  int         m_mode  [3];
  int         m_und   [3];
  int         m_ovf   [3];
  int         m_outv  [3];
  int         m_outd  [3];
  logic [2:0] m_q     [3][$];

  task automatic model_step(input int k, input bit r, input bit e, input bit v,
                            input logic [2:0] d);
    int sz;
    sz = m_q[k].size();
    if (r) begin
      m_mode[k] = 0; m_q[k].delete(); m_und[k] = 0; m_ovf[k] = 0;
      m_outv[k] = 0; m_outd[k] = 0;
    end else if (!e) begin
      m_mode[k] = 0; m_q[k].delete(); m_outv[k] = 0; m_outd[k] = 0;
    end else begin
      case (m_mode[k])
        0: begin
          m_mode[k] = 1; m_outv[k] = 0; m_outd[k] = 0;
        end
        1: begin
          m_outv[k] = 0; m_outd[k] = 0;
          if (v) begin
            if (sz < p_depth[k]) m_q[k].push_back(d);
            else if (m_ovf[k] < p_cmax[k]) m_ovf[k]++;
          end
          if (sz >= p_pre[k]) m_mode[k] = 2;
        end
        default: begin
          if (sz == 0) begin
            m_mode[k] = 1; m_outv[k] = 0; m_outd[k] = 0;
            if (m_und[k] < p_cmax[k]) m_und[k]++;
            if (v) m_q[k].push_back(d);
          end else begin
            m_outd[k] = m_q[k].pop_front();
            m_outv[k] = 1;
            if (v) m_q[k].push_back(d);
          end
        end
      endcase
    end
  endtask

  task automatic check_all();
    int ucv [3];
    int ocv [3];
    ucv[0] = uc0; ucv[1] = uc1; ucv[2] = uc2;
    ocv[0] = oc0; ocv[1] = oc1; ocv[2] = oc2;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("d%0d_out_valid", k), ov[k], m_outv[k]);
      chk($sformatf("d%0d_out_data", k), od[k], m_outd[k]);
      chk($sformatf("d%0d_state", k), st[k], m_mode[k]);
      chk($sformatf("d%0d_fill", k), fl[k], m_q[k].size());
      chk($sformatf("d%0d_underrun", k), ucv[k], m_und[k]);
      chk($sformatf("d%0d_overflow", k), ocv[k], m_ovf[k]);
    end
  endtask

  // Apply one cycle of inputs, advance the model at the edge, check mid-cycle.
  task automatic cycle(input bit r, input bit e, input bit v, input logic [2:0] d);
    rst = r; en = e; iv = v; id = d;
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_step(k, r, e, v, d);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int first_ov0, first_ov1;
    bit r, e, v;

    rst = 1'b1; en = 1'b1; iv = 1'b1; id = 3'd5;

    // Reset held with traffic present.
    repeat (3) cycle(1'b1, 1'b1, 1'b1, 3'd5);
    chk("rst_state", st[0], 0);
    chk("rst_fill", fl[0], 0);
    chk("rst_out_valid", ov[0], 0);
    chk("rst_out_data", od[0], 0);
    chk("rst_underrun", uc0, 0);
    chk("rst_overflow", oc0, 0);

    // Continuous input; the IDLE cycle's sample must be ignored.
    cycle(1'b0, 1'b1, 1'b1, 3'd7);
    first_ov0 = -1; first_ov1 = -1;
    for (int i = 0; i < 40; i++) begin
      cycle(1'b0, 1'b1, 1'b1, 3'(i));
      if (first_ov0 < 0 && ov[0]) begin
        first_ov0 = i;
        chk("first_data_d0", od[0], 0);
      end
      if (first_ov1 < 0 && ov[1]) begin
        first_ov1 = i;
        chk("first_data_d1", od[1], 0);
      end
    end
    chk("prefill_latency_d0", first_ov0, 9);
    chk("prefill_latency_d1", first_ov1, 17);
    chk("overflow_once_d1", oc1, 1);
    chk("overflow_none_d0", oc0, 0);

    // Repeated 12-cycle starvation gaps force underruns.
    for (int g = 0; g < 5; g++) begin
      repeat (12) cycle(1'b0, 1'b1, 1'b0, 3'd0);
      if (g == 0) chk("underrun_first_d0", uc0, 1);
      repeat (30) cycle(1'b0, 1'b1, 1'b1, 3'($urandom));
    end
    chk("underrun_count_d0", uc0, 5);
    chk("underrun_saturate_d2", uc2, 3);

    // Bursty unpacker: alternating 5-on/1-off and 6-on/1-off.
    for (int b = 0; b < 30; b++) begin
      repeat ((b % 2) ? 6 : 5) cycle(1'b0, 1'b1, 1'b1, 3'($urandom));
      cycle(1'b0, 1'b1, 1'b0, 3'($urandom));
    end
    repeat (20) cycle(1'b0, 1'b1, 1'b0, 3'd0);

    // Random traffic with occasional disable and reset.
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 199) == 0);
      e = ($urandom_range(0, 59) != 0);
      v = ($urandom_range(0, 3) != 0);
      cycle(r, e, v, 3'($urandom));
    end

    // Reach steady RUN, then drop enable.
    repeat (25) cycle(1'b0, 1'b1, 1'b1, 3'($urandom));
    chk("pre_disable_state_d0", st[0], 2);
    cycle(1'b0, 1'b0, 1'b1, 3'd3);
    chk("disable_state", st[0], 0);
    chk("disable_fill", fl[0], 0);
    chk("disable_out_valid", ov[0], 0);
    chk("disable_underrun_kept", uc0, m_und[0]);
    chk("disable_overflow_kept", oc1, m_ovf[1]);
    repeat (3) cycle(1'b0, 1'b1, 1'b1, 3'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
